sorter_ctrl: RTL
================

// Module: sorter_ctrl
// PURPOSE
//   Serial-in/serial-out controller around the combinational sorter.
//   Collects up to N words over a valid/ready stream into a load buffer and
//   presents the buffer to an internal sorter #(.N(N),.DW(DW)) instance.
//   Registers the sorted vector, then streams the words out in order.
//   Sits between a producer stream and a consumer needing sorted frames.
// PARAMETERS
//   N   5  words per frame (sorter width); N>=2
//   DW  8  bits per word
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      producer word valid
//   in_ready   out  1      controller accepts word (high only in LOAD)
//   in_data    in   DW     input word
//   in_last    in   1      marks final word of a short frame (<N words)
//   out_valid  out  1      sorted word valid (high only in DRAIN)
//   out_ready  in   1      consumer accepts word
//   out_data   out  DW     sorted word
//   out_last   out  1      marks final word of the frame, qualified by out_valid
//   busy       out  1      high in SORT or DRAIN
// BEHAVIOUR
//   Reset: state=LOAD, wr_cnt=0, rd_idx=0, frame_len=0, buffer words=PAD,
//     result register=PAD, out_valid=0, out_last=0, busy=0.
//     in_ready=1 once rst_n is released.
//   PAD = {DW{1'b1}} (ascending build).
//   Sorter output order: slot 0 = minimum, slot N-1 = maximum.
//   LOAD:
//     - in_ready=1.
//     - Accept when in_valid&in_ready: buf[wr_cnt]<=in_data; wr_cnt++.
//     - Leave to SORT on the accept where wr_cnt==N-1 or in_last=1.
//     - frame_len <= wr_cnt+1 on that accept.
//     - in_last on the Nth word is the same as a full frame.
//   SORT (exactly 1 cycle):
//     - Result register <= sorter output.
//     - Buffer refilled to PAD; wr_cnt<=0; rd_idx<=0.
//     - Go to DRAIN.
//   DRAIN:
//     - out_valid=1; out_data=res[rd_idx]; out_last=(rd_idx==frame_len-1).
//     - On out_valid&out_ready: rd_idx++.
//     - On the out_last handshake, go to LOAD.
//     - out_ready low stalls; out_data is held stable.
//   Padding:
//     - Unfilled slots hold PAD and therefore sort after all real words.
//     - Only frame_len words are emitted; pads are never output.
//     - A real word equal to PAD is indistinguishable from a pad and is still
//       emitted correctly, because counting is by frame_len.
//   Latency/throughput:
//     - Last word accepted at edge t, out_valid rises after edge t+1.
//     - First word available 2 cycles after the last accept.
//     - No overlap: in_ready=0 for all of SORT and DRAIN.
//   Counter widths: wr_cnt, rd_idx, frame_len are $clog2(N+1) bits. No wrap
//     beyond N-1 is possible.
//   Reset mid-operation: immediate return to reset state; partial frame
//     discarded; out_valid drops asynchronously.
//   in_valid while in_ready=0 is ignored; producer must hold.
// CONFIGURATION
//   SORTER_CTRL_DESC_EN defined:
//     - Descending output (largest first).
//     - PAD = {DW{1'b0}}.
//     - DRAIN reads res[N-1-rd_idx].
//   SORTER_CTRL_DESC_EN undefined:
//     - Ascending output as above.
//     - PAD = all ones; DRAIN reads res[rd_idx].
//   Handshake timing is identical in both builds.
// TESTING (N=5, DW=8, ascending unless noted)
//   1. Full frame 7,3,9,1,5 with out_ready=1
//      -> out 1,3,5,7,9; out_last on 9; out_valid first 2 cycles after 5.
//   2. Short frame 42,17 with in_last on 17
//      -> out 17,42; out_last on 42; no pad words emitted.
//   3. Frame 255,0,255,128,0
//      -> 0,0,128,255,255 (ties and PAD-valued data).
//   4. out_ready toggled 1,0,0,1 during DRAIN
//      -> out_data held while stalled; in_ready=0 throughout; no word lost.
//   5. rst_n pulsed low after 3 of 5 inputs
//      -> out_valid=0, in_ready=1 after release.
//      -> next frame 2,4,6,8,10 outputs 2,4,6,8,10 with no stale data.
//   6. SORTER_CTRL_DESC_EN, short frame 5,200,60 with in_last
//      -> out 200,60,5; out_last on 5.

Source files
------------

// File: rtl/sorter_ctrl.sv
// Serial-in/serial-out frame sorter: loads up to N words, sorts them in one cycle, then streams them out.
// Define SORTER_CTRL_DESC_EN for descending output (largest first); default build is ascending.

module sorter #(
  parameter int N  = 5,
  parameter int DW = 8
) (
  input  logic [N*DW-1:0] in_vec,
  output logic [N*DW-1:0] out_vec
);

  // Odd-even transposition network; slot 0 ends up holding the minimum.
  always_comb begin
    logic [DW-1:0] v [N];
    logic [DW-1:0] t;
    t = '0;
    out_vec = '0;
    for (int unsigned i = 0; i < N; i++) v[i] = in_vec[i*DW +: DW];
    for (int unsigned p = 0; p < N; p++) begin
      for (int unsigned i = p % 2; i + 1 < N; i += 2) begin
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) out_vec[i*DW +: DW] = v[i];
  end

endmodule

module sorter_ctrl #(
  parameter int N  = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int W  = $clog2(N + 1);
  localparam int IW = $clog2(N);
`ifdef SORTER_CTRL_DESC_EN
  localparam logic [DW-1:0] PAD = '0;
`else
  localparam logic [DW-1:0] PAD = '1;
`endif

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t          state, nstate;
  logic [W-1:0]    wr_cnt, rd_idx, frame_len;
  logic [DW-1:0]   ldbuf [N];
  logic [DW-1:0]   res   [N];
  logic [N*DW-1:0] sort_in, sort_out;
  logic [IW-1:0]   wr_sel, rd_sel;
  logic            acc, frame_end;

  sorter #(.N(N), .DW(DW)) u_sorter (
    .in_vec  (sort_in),
    .out_vec (sort_out)
  );

  always_comb begin
    sort_in = '0;
    for (int unsigned i = 0; i < N; i++) sort_in[i*DW +: DW] = ldbuf[i];
  end

  assign acc       = in_valid && in_ready;
  assign frame_end = (wr_cnt == W'(N - 1)) || in_last;
  assign wr_sel    = IW'(wr_cnt);
`ifdef SORTER_CTRL_DESC_EN
  // Sorter is always ascending, so descending output reads from the top slot down.
  assign rd_sel    = IW'(N - 1) - IW'(rd_idx);
`else
  assign rd_sel    = IW'(rd_idx);
`endif
  assign out_data  = res[rd_sel];

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (acc && frame_end) nstate = SORT;
      end
      SORT: begin
        busy   = 1'b1;
        nstate = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (rd_idx == frame_len - W'(1));
        if (out_ready && out_last) nstate = LOAD;
      end
      default: nstate = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      rd_idx    <= '0;
      frame_len <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        ldbuf[i] <= PAD;
        res[i]   <= PAD;
      end
    end else begin
      state <= nstate;
      case (state)
        LOAD: begin
          if (acc) begin
            ldbuf[wr_sel] <= in_data;
            wr_cnt        <= wr_cnt + W'(1);
            if (frame_end) frame_len <= wr_cnt + W'(1);
          end
        end
        SORT: begin
          for (int unsigned i = 0; i < N; i++) begin
            res[i]   <= sort_out[i*DW +: DW];
            ldbuf[i] <= PAD;
          end
          wr_cnt <= '0;
          rd_idx <= '0;
        end
        DRAIN: begin
          if (out_ready) rd_idx <= rd_idx + W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
